// File: rtl/handshake_sender.sv
// Transmit side of a 4-phase bundled-data req/ack link; tx_ack is synchronized before use.
// Optional build macro HS_TIMEOUT_EN adds a REQ/RELEASE watchdog and a timeout_err pulse.
module handshake_sender #(
   parameter int SIZE         = 8,
   parameter int SYNC_STAGES  = 2,
   parameter int SETUP_CYCLES = 1
`ifdef HS_TIMEOUT_EN
   ,
   parameter int TIMEOUT_CYCLES = 1024
`endif
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [SIZE-1:0] in_data,
   input  logic            in_valid,
   output logic            in_ready,
   output logic [SIZE-1:0] tx_data,
   output logic            tx_req,
   input  logic            tx_ack,
   output logic            busy,
   output logic            done
`ifdef HS_TIMEOUT_EN
   ,
   output logic            timeout_err
`endif
);

   localparam int SW = (SETUP_CYCLES > 1) ? $clog2(SETUP_CYCLES) : 1;
   localparam logic [SW-1:0] SETUP_LAST = SW'(SETUP_CYCLES - 1);

   localparam logic [1:0] IDLE    = 2'd0;
   localparam logic [1:0] SETUP   = 2'd1;
   localparam logic [1:0] REQ     = 2'd2;
   localparam logic [1:0] RELEASE = 2'd3;

   logic [1:0]             state;
   logic [SYNC_STAGES-1:0] sync;
   logic                   ack_s;
   logic [SW-1:0]          setup_cnt;
   logic                   to_hit;

   // tx_ack is asynchronous; only the last flop of this chain feeds the FSM
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) sync <= '0;
      else        sync <= {sync[SYNC_STAGES-2:0], tx_ack};
   end

   assign ack_s    = sync[SYNC_STAGES-1];
   assign in_ready = (state == IDLE);
   assign busy     = ~in_ready;

`ifdef HS_TIMEOUT_EN
   localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

   logic [TW-1:0] to_cnt;

   // a normal ack transition in the same cycle takes priority over the watchdog
   assign to_hit = ((state == REQ && !ack_s) || (state == RELEASE && ack_s)) &&
                   (to_cnt == TO_LAST);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         to_cnt      <= '0;
         timeout_err <= 1'b0;
      end else begin
         timeout_err <= to_hit;
         if (state == IDLE || state == SETUP || (state == REQ && ack_s))
            to_cnt <= '0;
         else
            to_cnt <= to_cnt + 1'b1;
      end
   end
`else
   assign to_hit = 1'b0;
`endif

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= IDLE;
         tx_req    <= 1'b0;
         tx_data   <= '0;
         done      <= 1'b0;
         setup_cnt <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (in_valid) begin
                  tx_data   <= in_data;
                  setup_cnt <= '0;
                  state     <= SETUP;
               end
            end
            SETUP: begin
               // a stale ack from the previous transfer holds us here until it clears
               if (setup_cnt == SETUP_LAST && !ack_s) begin
                  tx_req <= 1'b1;
                  state  <= REQ;
               end else if (setup_cnt != SETUP_LAST) begin
                  setup_cnt <= setup_cnt + 1'b1;
               end
            end
            REQ: begin
               if (ack_s) begin
                  tx_req <= 1'b0;
                  state  <= RELEASE;
               end else if (to_hit) begin
                  tx_req <= 1'b0;
                  state  <= IDLE;
               end
            end
            RELEASE: begin
               if (!ack_s) begin
                  done  <= 1'b1;
                  state <= IDLE;
               end else if (to_hit) begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_handshake_sender.sv
// Self-checking bench for handshake_sender: vector table, directed corner sequences,
// and a randomized responder checked against a timestamp-based protocol model.
module tb_handshake_sender;
   localparam int SIZE = 8;
   localparam int SYNC = 2;
   localparam int SC   = 1;
   localparam int LAT  = SYNC + 1;
`ifdef HS_TIMEOUT_EN
   localparam int TO   = 16;
   localparam int SLOW = 8;
`else
   localparam int SLOW = 20;
`endif

   logic            clk = 1'b0;
   logic            reset = 1'b0;
   logic [SIZE-1:0] in_data = '0;
   logic            in_valid = 1'b0;
   logic            tx_ack = 1'b0;
   logic            mirror = 1'b0;
   logic            in_ready, busy, done, tx_req;
   logic [SIZE-1:0] tx_data;
`ifdef HS_TIMEOUT_EN
   logic            timeout_err;
`endif

   always #5 clk = ~clk;

   handshake_sender #(
      .SIZE(SIZE), .SYNC_STAGES(SYNC), .SETUP_CYCLES(SC)
`ifdef HS_TIMEOUT_EN
      , .TIMEOUT_CYCLES(TO)
`endif
   ) dut (
      .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
      .in_ready(in_ready), .tx_data(tx_data), .tx_req(tx_req), .tx_ack(tx_ack),
      .busy(busy), .done(done)
`ifdef HS_TIMEOUT_EN
      , .timeout_err(timeout_err)
`endif
   );

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // inputs and the responder change 1 time unit after the active edge
   task automatic tick();
      @(posedge clk);
      #1;
      if (mirror) tx_ack = tx_req;
   endtask

   task automatic wait_req(input logic lvl, input int limit);
      int n = 0;
      while (tx_req !== lvl && n < limit) begin tick(); n++; end
      chk("wait_req", {31'd0, tx_req}, {31'd0, lvl});
   endtask

   task automatic wait_done(input int limit);
      int n = 0;
      while (done !== 1'b1 && n < limit) begin tick(); n++; end
      chk("wait_done", {31'd0, done}, 32'd1);
   endtask

   typedef struct {
      logic            req;
      logic            dn;
      logic            rdy;
      logic [SIZE-1:0] data;
   } vec_t;
   vec_t vt [9];

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
      $fatal(1, "watchdog");
   end

   initial begin
      int nacc, ndone, n, e, acc_e, rise_e, fall_e, dly;
      logic [SIZE-1:0] cur, exp_data;
      logic active;

      vt[0] = '{1'b0, 1'b0, 1'b0, 8'hA5};
      vt[1] = '{1'b1, 1'b0, 1'b0, 8'hA5};
      vt[2] = '{1'b1, 1'b0, 1'b0, 8'hA5};
      vt[3] = '{1'b1, 1'b0, 1'b0, 8'hA5};
      vt[4] = '{1'b0, 1'b0, 1'b0, 8'hA5};
      vt[5] = '{1'b0, 1'b0, 1'b0, 8'hA5};
      vt[6] = '{1'b0, 1'b0, 1'b0, 8'hA5};
      vt[7] = '{1'b0, 1'b1, 1'b1, 8'hA5};
      vt[8] = '{1'b0, 1'b0, 1'b1, 8'hA5};

      // reset with ack and valid asserted
      tx_ack = 1'b1; in_valid = 1'b1; in_data = 8'h77;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_req", {31'd0, tx_req}, 32'd0);
      chk("rst_data", {24'd0, tx_data}, 32'd0);
      chk("rst_done", {31'd0, done}, 32'd0);
      reset = 1'b1;
      #1;
      chk("rel_rdy", {31'd0, in_ready}, 32'd1);
      chk("rel_busy", {31'd0, busy}, 32'd0);
      chk("rel_req", {31'd0, tx_req}, 32'd0);
      in_valid = 1'b0; tx_ack = 1'b0;
      repeat (4) tick();
      chk("idle_data", {24'd0, tx_data}, 32'd0);

      // single word, immediate responder, vector table per edge
      mirror = 1'b1; in_data = 8'hA5; in_valid = 1'b1;
      for (int i = 0; i < 9; i++) begin
         tick();
         if (i == 0) begin in_valid = 1'b0; in_data = 8'hFF; end
         chk($sformatf("vec%0d_req", i), {31'd0, tx_req}, {31'd0, vt[i].req});
         chk($sformatf("vec%0d_done", i), {31'd0, done}, {31'd0, vt[i].dn});
         chk($sformatf("vec%0d_rdy", i), {31'd0, in_ready}, {31'd0, vt[i].rdy});
         chk($sformatf("vec%0d_data", i), {24'd0, tx_data}, {24'd0, vt[i].data});
      end
      mirror = 1'b0;

      // stale ack held high at accept
      tx_ack = 1'b1;
      repeat (3) tick();
      in_data = 8'h3C; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      chk("stale_data", {24'd0, tx_data}, 32'h3C);
      repeat (5) begin
         tick();
         chk("stale_req", {31'd0, tx_req}, 32'd0);
         chk("stale_busy", {31'd0, busy}, 32'd1);
      end
      tx_ack = 1'b0;
      tick(); chk("stale_req1", {31'd0, tx_req}, 32'd0);
      tick(); chk("stale_req2", {31'd0, tx_req}, 32'd0);
      tick(); chk("stale_rise", {31'd0, tx_req}, 32'd1);
      mirror = 1'b1; tx_ack = 1'b1;
      wait_done(20);

      // back-to-back: accept in each done cycle, garbage on in_data while busy
      nacc = 0; ndone = 0; n = 0; cur = '0;
      in_valid = 1'b1; in_data = 8'h01;
      while ((nacc < 3 || ndone < 3) && n < 200) begin
         logic acc;
         logic [SIZE-1:0] w;
         acc = in_valid && in_ready;
         w = in_data;
         tick(); n++;
         if (acc) begin
            nacc++; cur = w;
            chk("b2b_data", {24'd0, tx_data}, nacc);
         end else begin
            chk("b2b_hold", {24'd0, tx_data}, {24'd0, cur});
         end
         if (done) ndone++;
         if (in_ready) begin
            if (nacc < 3) in_data = 8'(nacc + 1);
            else in_valid = 1'b0;
         end else begin
            in_data = 8'($urandom);
         end
      end
      chk("b2b_nacc", nacc, 32'd3);
      repeat (5) begin tick(); if (done) ndone++; end
      chk("b2b_ndone", ndone, 32'd3);
      mirror = 1'b0; tx_ack = 1'b0;

      // slow responder
      in_data = 8'h5A; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      wait_req(1'b1, 10);
      repeat (SLOW) begin
         tick();
         chk("slow_req", {31'd0, tx_req}, 32'd1);
         chk("slow_nodone", {31'd0, done}, 32'd0);
      end
      tx_ack = 1'b1;
      tick(); chk("slow_req_a", {31'd0, tx_req}, 32'd1);
      tick(); chk("slow_req_b", {31'd0, tx_req}, 32'd1);
      tick(); chk("slow_fall", {31'd0, tx_req}, 32'd0);
      repeat (5) begin
         tick();
         chk("slow_rel_done", {31'd0, done}, 32'd0);
         chk("slow_rel_busy", {31'd0, busy}, 32'd1);
      end
      tx_ack = 1'b0;
      tick(); chk("slow_done_a", {31'd0, done}, 32'd0);
      tick(); chk("slow_done_b", {31'd0, done}, 32'd0);
      tick(); chk("slow_done", {31'd0, done}, 32'd1);
      chk("slow_data", {24'd0, tx_data}, 32'h5A);

      // reset asserted during REQ drops tx_req without a clock edge
      in_data = 8'hC3; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      wait_req(1'b1, 10);
      reset = 1'b0;
      #1;
      chk("mid_rst_req", {31'd0, tx_req}, 32'd0);
      chk("mid_rst_data", {24'd0, tx_data}, 32'd0);
      reset = 1'b1;
      #1;
      chk("mid_rel_rdy", {31'd0, in_ready}, 32'd1);
      repeat (4) tick();

`ifdef HS_TIMEOUT_EN
      // receiver never answers: watchdog aborts the transfer
      in_data = 8'hE7; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      tick();
      chk("to_rise", {31'd0, tx_req}, 32'd1);
      for (int k = 2; k <= 16; k++) begin
         tick();
         chk("to_hold", {31'd0, tx_req}, 32'd1);
         chk("to_noerr", {31'd0, timeout_err}, 32'd0);
      end
      tick();
      chk("to_fall", {31'd0, tx_req}, 32'd0);
      chk("to_err", {31'd0, timeout_err}, 32'd1);
      chk("to_done", {31'd0, done}, 32'd0);
      chk("to_rdy", {31'd0, in_ready}, 32'd1);
      tick();
      chk("to_err_clr", {31'd0, timeout_err}, 32'd0);
`endif

      // randomized traffic and responder against a timestamp model
      e = 0; active = 1'b0; acc_e = 0; rise_e = -1; fall_e = -1; dly = 0;
      exp_data = tx_data === 8'h00 ? 8'h00 : 8'hE7;
      for (int it = 0; it < 1500; it++) begin
         logic acc, exp_req, exp_done;
         logic [SIZE-1:0] w;
         acc = in_valid && !active;
         w = in_data;
         tick(); e++;
         if (acc) begin
            active = 1'b1; acc_e = e; rise_e = -1; fall_e = -1;
            exp_data = w; dly = $urandom_range(0, 4);
         end
         exp_req  = active && (e >= acc_e + SC) && (rise_e < 0 || e < rise_e + LAT);
         exp_done = active && (fall_e >= 0) && (e == fall_e + LAT);
         if (exp_done) active = 1'b0;
         chk("rnd_req", {31'd0, tx_req}, {31'd0, exp_req});
         chk("rnd_done", {31'd0, done}, {31'd0, exp_done});
         chk("rnd_data", {24'd0, tx_data}, {24'd0, exp_data});
         chk("rnd_rdy", {31'd0, in_ready}, {31'd0, !active});
         chk("rnd_busy", {31'd0, busy}, {31'd0, active});
         if (active) begin
            if (rise_e < 0 && exp_req) begin
               if (dly == 0) begin tx_ack = 1'b1; rise_e = e; dly = $urandom_range(0, 4); end
               else dly--;
            end else if (rise_e >= 0 && fall_e < 0 && !exp_req) begin
               if (dly == 0) begin tx_ack = 1'b0; fall_e = e; end
               else dly--;
            end
         end
         in_valid = ($urandom_range(0, 1) == 1);
         in_data = 8'($urandom);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
